disp_recip_half: RTL and testbench
==================================

# disp_recip_half

Disparity-to-depth reciprocal stage of the disp2depth path: converts an unsigned sub-pixel disparity into depth = K / disparity, emitted as an IEEE-754 half-precision value. Its outputs drive the half-to-8.8 fixed-point converter directly: out_data feeds its s_axis_a_tdata, out_valid feeds its en, and both blocks share aclk/rstn/clken. A sequential restoring divider produces one quotient bit per enabled cycle, followed by a normalise-and-pack step.

## Interface
- DISP_W, 12, disparity input width (unsigned)
- DISP_FRAC, 4, fractional bits of disparity (disp = disp_in / 2^DISP_FRAC)
- K_W, 20, width of the depth constant
- K, 4800, focal·baseline constant (unsigned, < 2^K_W)
- aclk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- clken  in  1  global clock enable; no state changes when low
- in_valid  in  1  disparity sample offered
- in_ready  out  1  block idle, accepts a sample
- disp_in  in  DISP_W  disparity, unsigned fixed point
- out_valid  out  1  out_data valid; one enabled cycle per result
- out_data  out  16  half-float depth, sign always 0

## Operation
- Local QF = 14 (quotient fraction bits). Dividend N = K << (DISP_FRAC+QF), width DW = K_W+DISP_FRAC+QF (38 by default).
- Q = floor(N / disp_in), computed by restoring division, MSB first, one bit per clken cycle, DW iterations. Remainder register width DISP_W+1. Iteration counter 6 bits.
- The result is Q·2^-QF = depth.
- States: IDLE, DIV, NORM, OUT.
  - IDLE: in_ready=1. Accepts on in_valid & clken and latches disp_in.
    - If disp_in==0, goes to OUT with out_data=16'h7C00.
    - Otherwise loads the dividend, clears the remainder and counter, and goes to DIV.
  - DIV: one quotient bit per enabled cycle. Goes to NORM after bit 0.
  - NORM, one enabled cycle, resolved in this order:
    - Overflow (any of Q[DW-1:30] set, i.e. depth ≥ 2^16): 16'h7C00.
    - Q==0: 16'h0000.
    - Otherwise, let p be the index of the leading one in Q[29:0]:
      - exponent = p+1 (range 1..30, so no subnormals)
      - mantissa = the 10 bits directly below the leading one, zero-filled on the right when p<10
      - truncation only, no rounding (round toward zero, consistent with the downstream converter)
  - OUT: out_valid=1 for exactly one enabled cycle, then IDLE.
- out_data holds its last value until the next NORM or zero-accept overwrites it.
- in_valid while not in IDLE is ignored; the sample is not captured.

## Timing
- Reset values: state=IDLE, in_ready=1 once out of reset, out_valid=0, out_data=16'h0000, counter=0, registers zeroed.
- Latency is counted in enabled cycles after the accept edge:
  - DIV occupies cycles 1..DW.
  - NORM is cycle DW+1.
  - out_valid is high during cycle DW+2 (cycle 40 by default).
- Zero disparity: out_valid high in cycle 1 after accept.
- Throughput: one sample per DW+3 enabled cycles (41 default). The next accept is possible in the cycle after OUT.
- clken low: all registers hold, including out_valid. A held out_valid therefore represents a single result; the downstream stage samples on clken too.
- rstn asserted mid-division: aborts immediately to IDLE, the partial result is discarded, and no out_valid is produced.
- disp_in and in_valid are only sampled on the accept edge. Changes at any other time have no effect.

## Test plan
- K=4800, disp_in=16 (disp 1.0) -> out_data=16'h6CB0 (4800.0), out_valid exactly at enabled cycle 40 after accept, width 1 cycle.
- disp_in=75 -> 16'h6400 (1024.0, exact power of two, mantissa 0). disp_in=4095 -> 16'h4CB0 (18.75, truncated from 18.7546).
- disp_in=1 (depth 76800) -> 16'h7C00 overflow. disp_in=0 -> 16'h7C00 with out_valid at cycle 1. Chained into the 8.8 converter, both give 16'hFFFF.
- Back-to-back in_valid held high with 16, 75, 16 -> three results in order, spaced 41 cycles apart. in_ready low throughout DIV/NORM/OUT; no extra or lost samples.
- clken toggled pseudo-randomly at 50% during a disp_in=16 division -> same 16'h6CB0. Latency is 40 enabled cycles; out_valid is held across disabled cycles and never double-counted.
- rstn pulsed low at DIV cycle 20 -> out_valid stays 0, in_ready=1 after release. A new disp_in=75 then yields 16'h6400.

Source files
------------

// File: rtl/disp_recip_half.sv
// disp_recip_half
// Converts an unsigned fixed-point disparity into depth = K / disparity and
// emits it as an IEEE-754 half-precision value. A restoring divider produces
// one quotient bit per enabled cycle. A single normalise-and-pack cycle then
// turns the quotient into sign/exponent/mantissa fields.
//
// The quotient Q carries QF fraction bits, so bit i of Q has weight 2^(i-QF).
// With QF = 14 the half exponent field for a leading one at bit p is
// (p - 14) + 15 = p + 1. Leading ones in Q[29:0] therefore map to exponents
// 1..30. That range needs no subnormal handling and cannot reach infinity.
// Any set bit at or above Q[30] means depth >= 2^16 and saturates to +inf.
module disp_recip_half #(
  parameter int          DISP_W    = 12,
  parameter int          DISP_FRAC = 4,
  parameter int          K_W       = 20,
  parameter int unsigned K         = 4800
) (
  input  logic              aclk,
  input  logic              rstn,
  input  logic              clken,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DISP_W-1:0] disp_in,
  output logic              out_valid,
  output logic [15:0]       out_data
);

  // Quotient fraction bits and derived widths.
  localparam int QF = 14;
  localparam int DW = K_W + DISP_FRAC + QF;
  localparam int RW = DISP_W + 1;

  // Dividend K * 2^(DISP_FRAC+QF). The disparity scale cancels, and QF
  // fraction bits are left in the quotient.
  localparam logic [DW-1:0] DIVIDEND  = DW'(K) << (DISP_FRAC + QF);
  localparam logic [5:0]    LAST_ITER = 6'(DW - 1);

  localparam logic [15:0] HALF_INF  = 16'h7C00;
  localparam logic [15:0] HALF_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_NORM = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Datapath registers. quo_reg starts as the dividend and shifts left once
  // per iteration. Each new quotient bit enters at the LSB, so after DW
  // iterations the register holds Q.
  logic [DISP_W-1:0] disp_reg;
  logic [RW-1:0]     rem_reg;
  logic [DW-1:0]     quo_reg;
  logic [5:0]        cnt_reg;
  logic [15:0]       out_data_reg;

  // Division step signals.
  logic [RW:0]   rem_shift;
  logic [RW:0]   rem_diff;
  logic          rem_ge;
  logic [RW-1:0] rem_next;
  logic [DW-1:0] quo_next;

  // Normalise signals.
  logic          q_ovf;
  logic [29:0]   q_low;
  logic [4:0]    lead_pos;
  logic [4:0]    half_exp;
  logic [9:0]    half_mant;
  logic [15:0]   half_packed;

  logic          disp_zero;
  logic          div_last;

  assign disp_zero = (disp_in == '0);
  assign div_last  = (cnt_reg == LAST_ITER);

  // State register: the asynchronous reset aborts any division in flight.
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: a transition happens only on an enabled cycle.
  always_comb begin
    state_next = state_reg;
    if (clken) begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            state_next = disp_zero ? S_OUT : S_DIV;
          end
        end
        S_DIV: begin
          if (div_last) begin
            state_next = S_NORM;
          end
        end
        S_NORM:  state_next = S_OUT;
        S_OUT:   state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Output decode: ready while idle, valid during the single OUT state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      S_IDLE:  in_ready  = 1'b1;
      S_OUT:   out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  assign out_data = out_data_reg;

  // One restoring-division step. Shift the next dividend bit into the
  // remainder. Subtract the divisor when that is possible, and record the
  // quotient bit.
  always_comb begin
    rem_shift = {rem_reg, quo_reg[DW-1]};
    rem_diff  = rem_shift - (RW + 1)'(disp_reg);
    rem_ge    = (rem_shift >= (RW + 1)'(disp_reg));
    rem_next  = rem_ge ? RW'(rem_diff) : RW'(rem_shift);
    quo_next  = {quo_reg[DW-2:0], rem_ge};
  end

  // Leading-one search over the in-range part of the quotient. The highest
  // set bit wins.
  always_comb begin
    q_ovf    = |quo_reg[DW-1:30];
    q_low    = quo_reg[29:0];
    lead_pos = 5'd0;
    for (int i = 0; i < 30; i++) begin
      if (q_low[i]) begin
        lead_pos = 5'(i);
      end
    end
  end

  // Pack the half float. The leading one is shifted up to bit 29, and the
  // ten bits under it become the mantissa. Short values are zero-filled on
  // the right. Lower bits are truncated, which rounds toward zero.
  always_comb begin
    half_exp    = lead_pos + 5'd1;
    half_mant   = 10'((q_low << (5'd29 - lead_pos)) >> 19);
    half_packed = {1'b0, half_exp, half_mant};
    if (q_ovf) begin
      half_packed = HALF_INF;
    end else if (q_low == '0) begin
      half_packed = HALF_ZERO;
    end
  end

  // Datapath registers. They load on accept, iterate in DIV and capture the
  // packed result in NORM. Every register holds while clken is low.
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      disp_reg     <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      cnt_reg      <= '0;
      out_data_reg <= '0;
    end else if (clken) begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            disp_reg <= disp_in;
            if (disp_zero) begin
              out_data_reg <= HALF_INF;
            end else begin
              quo_reg <= DIVIDEND;
              rem_reg <= '0;
              cnt_reg <= '0;
            end
          end
        end
        S_DIV: begin
          quo_reg <= quo_next;
          rem_reg <= rem_next;
          cnt_reg <= cnt_reg + 6'd1;
        end
        S_NORM: begin
          out_data_reg <= half_packed;
        end
        default: begin
          out_data_reg <= out_data_reg;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_recip_half.sv
// tb_disp_recip_half
// Directed vectors for the disparity-to-depth reciprocal stage. Expected half
// values and latencies are hand-derived constants for K = 4800, DISP_FRAC = 4.
module tb_disp_recip_half;

  logic        aclk;
  logic        rstn;
  logic        clken;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] disp_in;
  logic        out_valid;
  logic [15:0] out_data;

  int n_checks = 0;
  int n_pass   = 0;

  disp_recip_half #(
    .DISP_W   (12),
    .DISP_FRAC(4),
    .K_W      (20),
    .K        (4800)
  ) dut (
    .aclk     (aclk),
    .rstn     (rstn),
    .clken    (clken),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .disp_in  (disp_in),
    .out_valid(out_valid),
    .out_data (out_data)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // One transaction. Accept d, then walk enabled cycles and record when
  // out_valid first appears and how many enabled cycles it was consumed in.
  task automatic run_one(input string tag, input logic [11:0] d, input logic [15:0] exp,
                         input int exp_lat, input bit rnd_en);
    int c;
    int lat;
    int seen;
    int guard;
    int busy_ready;
    logic [15:0] got;
    logic en;
    check_val({tag, " idle_ready"}, 32'(in_ready), 32'd1);
    disp_in  = d;
    in_valid = 1'b1;
    clken    = 1'b1;
    tick();
    in_valid   = 1'b0;
    disp_in    = 12'hABC;
    c          = 1;
    lat        = -1;
    seen       = 0;
    guard      = 0;
    busy_ready = 0;
    got        = 16'hxxxx;
    while (c <= exp_lat + 1 && guard < 1000) begin
      en    = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
      clken = en;
      if (out_valid) begin
        if (lat < 0) begin
          lat = c;
          got = out_data;
        end
        if (en) seen++;
      end
      if (lat < 0 && in_ready) busy_ready++;
      tick();
      guard++;
      if (en) c++;
    end
    clken = 1'b1;
    check_val({tag, " timeout"}, 32'(guard < 1000), 32'd1);
    check_val({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_val({tag, " data"}, 32'(got), 32'(exp));
    check_val({tag, " valid_count"}, 32'(seen), 32'd1);
    check_val({tag, " busy_ready"}, 32'(busy_ready), 32'd0);
    check_val({tag, " hold"}, 32'(out_data), 32'(exp));
  endtask

  initial begin
    int c;
    int nacc;
    int nres;
    int ov_cnt;
    int rdy_hi;
    bit acc;
    int res_t[3];
    logic [15:0] res_d[3];

    rstn     = 1'b0;
    clken    = 1'b0;
    in_valid = 1'b0;
    disp_in  = 12'd0;

    // Reset state.
    repeat (3) tick();
    check_val("reset out_valid", 32'(out_valid), 32'd0);
    check_val("reset out_data", 32'(out_data), 32'h0000);
    @(negedge aclk);
    rstn  = 1'b1;
    clken = 1'b1;
    tick();
    check_val("reset in_ready", 32'(in_ready), 32'd1);

    // A sample offered with clken low must not be accepted.
    clken    = 1'b0;
    in_valid = 1'b1;
    disp_in  = 12'd16;
    repeat (3) tick();
    check_val("clken_low no_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    clken    = 1'b1;
    tick();

    // Single transactions.
    run_one("d16",   12'd16,   16'h6CB0, 40, 1'b0);
    run_one("d75",   12'd75,   16'h6400, 40, 1'b0);
    run_one("d4095", 12'd4095, 16'h4CB0, 40, 1'b0);
    run_one("d32",   12'd32,   16'h68B0, 40, 1'b0);
    run_one("d3",    12'd3,    16'h7640, 40, 1'b0);
    run_one("d2",    12'd2,    16'h78B0, 40, 1'b0);
    run_one("d1",    12'd1,    16'h7C00, 40, 1'b0);
    run_one("d0",    12'd0,    16'h7C00, 1,  1'b0);

    // Back-to-back with in_valid held high: 16, 75, 16.
    clken    = 1'b1;
    disp_in  = 12'd16;
    in_valid = 1'b1;
    c = 0; nacc = 0; nres = 0; ov_cnt = 0; rdy_hi = 0;
    while (c <= 122) begin
      if (in_ready) rdy_hi++;
      if (out_valid) begin
        ov_cnt++;
        if (nres < 3) begin
          res_t[nres] = c;
          res_d[nres] = out_data;
          nres++;
        end
      end
      acc = in_ready && in_valid;
      tick();
      if (acc) begin
        nacc++;
        case (nacc)
          1:       disp_in = 12'd75;
          2:       disp_in = 12'd16;
          default: in_valid = 1'b0;
        endcase
      end
      c++;
    end
    in_valid = 1'b0;
    check_val("b2b accepts", 32'(nacc), 32'd3);
    check_val("b2b ready_cycles", 32'(rdy_hi), 32'd3);
    check_val("b2b results", 32'(ov_cnt), 32'd3);
    check_val("b2b data0", 32'(res_d[0]), 32'h6CB0);
    check_val("b2b data1", 32'(res_d[1]), 32'h6400);
    check_val("b2b data2", 32'(res_d[2]), 32'h6CB0);
    check_val("b2b t0", 32'(res_t[0]), 32'd40);
    check_val("b2b gap01", 32'(res_t[1] - res_t[0]), 32'd41);
    check_val("b2b gap12", 32'(res_t[2] - res_t[1]), 32'd41);
    tick();

    // Pseudo-random clken during a division.
    run_one("rnd_clken d16", 12'd16, 16'h6CB0, 40, 1'b1);
    tick();

    // Reset pulse in the middle of a division.
    disp_in  = 12'd16;
    in_valid = 1'b1;
    clken    = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (19) tick();
    #2 rstn = 1'b0;
    #1;
    check_val("midreset out_valid", 32'(out_valid), 32'd0);
    #1 rstn = 1'b1;
    ov_cnt = 0;
    repeat (60) begin
      tick();
      if (out_valid) ov_cnt++;
    end
    check_val("midreset no_result", 32'(ov_cnt), 32'd0);
    check_val("midreset in_ready", 32'(in_ready), 32'd1);
    run_one("after_reset d75", 12'd75, 16'h6400, 40, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
